// File: rtl/simple_pkg.sv
// Shared constants for the SIMPLE pipeline: opcodes, branch conditions,
// flag bit positions, shifter kinds and the branch-shadow range helper.
package simple_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;
    localparam logic [3:0] OP_NP7 = 4'd7;
    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_SLR = 4'd9;
    localparam logic [3:0] OP_SRL = 4'd10;
    localparam logic [3:0] OP_SRA = 4'd11;
    localparam logic [3:0] OP_IN  = 4'd12;
    localparam logic [3:0] OP_OUT = 4'd13;
    localparam logic [3:0] OP_NPE = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    localparam logic [2:0] COND_BE  = 3'd0;
    localparam logic [2:0] COND_BLT = 3'd1;
    localparam logic [2:0] COND_BLE = 3'd2;
    localparam logic [2:0] COND_BNE = 3'd3;
    localparam logic [2:0] COND_B   = 3'd4;

    // Bit positions inside the {S,Z,C,V} flag word
    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Encoded to match opcode[1:0] of the shift opcodes 8..11
    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_ROL = 2'd1,
        SH_SRL = 2'd2,
        SH_SRA = 2'd3
    } shift_type_e;

    // Keeps the shadow length inside the 1..3 range the 2-bit counter supports
    function automatic logic [1:0] shadow_clamp(input int n);
        if (n < 1)
            return 2'd1;
        else if (n > 3)
            return 2'd3;
        else
            return 2'(n);
    endfunction

endpackage

// File: rtl/p3_shifter.sv
// Combinational 16-bit shifter/rotator; carry is the last bit shifted out.
module p3_shifter
    import simple_pkg::*;
(
    input  logic [15:0]  a_i,
    input  logic [3:0]   amount_i,
    input  shift_type_e  type_i,
    output logic [15:0]  result_o,
    output logic         carry_o
);

    logic [4:0] amt;
    logic [4:0] lidx;
    logic [4:0] ridx;

    // A zero amount passes A through with carry cleared
    always_comb begin
        amt      = {1'b0, amount_i};
        lidx     = 5'd16 - amt;
        ridx     = amt - 5'd1;
        result_o = a_i;
        carry_o  = 1'b0;
        if (amount_i != 4'd0) begin
            case (type_i)
                SH_SLL: begin
                    result_o = a_i << amount_i;
                    carry_o  = a_i[lidx[3:0]];
                end
                SH_ROL: begin
                    result_o = (a_i << amount_i) | (a_i >> lidx);
                    carry_o  = a_i[lidx[3:0]];
                end
                SH_SRL: begin
                    result_o = a_i >> amount_i;
                    carry_o  = a_i[ridx[3:0]];
                end
                default: begin
                    result_o = 16'($signed(a_i) >>> amount_i);
                    carry_o  = a_i[ridx[3:0]];
                end
            endcase
        end
    end

endmodule

// File: rtl/p3_execute.sv
// Execute stage: ALU/shifter, SZCV flags, branch resolution with a wrong-path
// shadow, IN/OUT/HLT handling, and the registers toward memory/writeback.
module p3_execute
    import simple_pkg::*;
#(
    parameter int BRANCH_SHADOW = 2
) (
    input  logic        clockp3,
    input  logic        reset,
    input  logic        stall,
    input  logic [15:0] alu1,
    input  logic [15:0] alu2,
    input  logic [3:0]  opcode,
    input  logic        writereg,
    input  logic [1:0]  memwrite,
    input  logic [2:0]  regaddress,
    input  logic [15:0] address,
    input  logic [15:0] storedata,
    input  logic        isbranch,
    input  logic [2:0]  cond,
    input  logic [15:0] pcp2,
    input  logic        haltin,
    input  logic [15:0] inport,
    output logic [15:0] aluresult,
    output logic        writeregout,
    output logic [1:0]  memwriteout,
    output logic [2:0]  regaddressout,
    output logic [15:0] addressout,
    output logic [15:0] storedataout,
    output logic        branchtaken,
    output logic [15:0] branchtarget,
    output logic [3:0]  flags,
    output logic [15:0] outport,
    output logic        outvalid,
    output logic        haltout
);

    localparam logic [1:0] SHADOW_LOAD = shadow_clamp(BRANCH_SHADOW);

    logic [15:0] result_q, result_d;
    logic        wr_q, wr_d;
    logic [1:0]  mw_q, mw_d;
    logic [2:0]  ra_q;
    logic [15:0] addr_q, sd_q;
    logic        taken_q, taken_d;
    logic [15:0] target_q;
    logic [3:0]  flags_q, flags_d;
    logic [15:0] outport_q, outport_d;
    logic        outvalid_q, outvalid_d;
    logic        halt_q, halt_d;
    logic [1:0]  shadow_q, shadow_d;

    logic [15:0] sh_result;
    logic        sh_carry;
    logic        squash;
    logic        cond_met;
    logic [15:0] alu_r;
    logic        alu_c;
    logic        alu_v;
    logic [16:0] wide;

    p3_shifter u_shifter (
        .a_i      (alu1),
        .amount_i (alu2[3:0]),
        .type_i   (shift_type_e'(opcode[1:0])),
        .result_o (sh_result),
        .carry_o  (sh_carry)
    );

    assign squash = (shadow_q != 2'd0) | halt_q;

    // ALU result with carry/overflow for the flag-setting opcodes
    always_comb begin
        alu_r = 16'd0;
        alu_c = 1'b0;
        alu_v = 1'b0;
        wide  = 17'd0;
        case (opcode)
            OP_ADD: begin
                wide  = {1'b0, alu1} + {1'b0, alu2};
                alu_r = wide[15:0];
                alu_c = wide[16];
                alu_v = (alu1[15] == alu2[15]) && (alu_r[15] != alu1[15]);
            end
            OP_SUB, OP_CMP: begin
                alu_r = alu1 - alu2;
                alu_c = alu1 < alu2;
                alu_v = (alu1[15] != alu2[15]) && (alu_r[15] != alu1[15]);
            end
            OP_AND: alu_r = alu1 & alu2;
            OP_OR:  alu_r = alu1 | alu2;
            OP_XOR: alu_r = alu1 ^ alu2;
            OP_MOV: alu_r = alu1;
            OP_SLL, OP_SLR, OP_SRL, OP_SRA: begin
                alu_r = sh_result;
                alu_c = sh_carry;
            end
            OP_IN:  alu_r = inport;
            default: alu_r = 16'd0;
        endcase
    end

    // Branch condition evaluated against the flags from before this cycle
    always_comb begin
        case (cond)
            COND_BE:  cond_met = flags_q[FLAG_Z];
            COND_BLT: cond_met = flags_q[FLAG_S] ^ flags_q[FLAG_V];
            COND_BLE: cond_met = flags_q[FLAG_Z] | (flags_q[FLAG_S] ^ flags_q[FLAG_V]);
            COND_BNE: cond_met = ~flags_q[FLAG_Z];
            COND_B:   cond_met = 1'b1;
            default:  cond_met = 1'b0;
        endcase
    end

    // Next-state for results, squash-gated controls, flags, shadow and halt
    always_comb begin
        result_d   = (memwrite != 2'b00) ? 16'd0 : alu_r;
        wr_d       = writereg & ~squash & (opcode != OP_CMP) &
                     (opcode != OP_NP7) & (opcode != OP_NPE);
        mw_d       = squash ? 2'b00 : memwrite;
        taken_d    = isbranch & ~squash & cond_met;
        outvalid_d = (opcode == OP_OUT) & ~squash;
        outport_d  = outvalid_d ? alu1 : outport_q;
        halt_d     = halt_q | (haltin & ~squash);
        flags_d    = flags_q;
        if (((opcode <= OP_MOV) || ((opcode >= OP_SLL) && (opcode <= OP_SRA))) &&
            (memwrite == 2'b00) && !isbranch && !squash) begin
            flags_d[FLAG_S] = alu_r[15];
            flags_d[FLAG_Z] = (alu_r == 16'd0);
            flags_d[FLAG_C] = alu_c;
            flags_d[FLAG_V] = alu_v;
        end
        if (taken_d)
            shadow_d = SHADOW_LOAD;
        else if (shadow_q != 2'd0)
            shadow_d = shadow_q - 2'd1;
        else
            shadow_d = shadow_q;
    end

    // Stage registers: reset clears all, stall holds state and drops the pulses
    always_ff @(posedge clockp3) begin
        if (reset) begin
            result_q   <= 16'd0;
            wr_q       <= 1'b0;
            mw_q       <= 2'b00;
            ra_q       <= 3'd0;
            addr_q     <= 16'd0;
            sd_q       <= 16'd0;
            taken_q    <= 1'b0;
            target_q   <= 16'd0;
            flags_q    <= 4'd0;
            outport_q  <= 16'd0;
            outvalid_q <= 1'b0;
            halt_q     <= 1'b0;
            shadow_q   <= 2'd0;
        end else if (stall) begin
            taken_q    <= 1'b0;
            outvalid_q <= 1'b0;
        end else begin
            result_q   <= result_d;
            wr_q       <= wr_d;
            mw_q       <= mw_d;
            ra_q       <= regaddress;
            addr_q     <= address;
            sd_q       <= storedata;
            taken_q    <= taken_d;
            target_q   <= pcp2 + address;
            flags_q    <= flags_d;
            outport_q  <= outport_d;
            outvalid_q <= outvalid_d;
            halt_q     <= halt_d;
            shadow_q   <= shadow_d;
        end
    end

    assign aluresult     = result_q;
    assign writeregout   = wr_q;
    assign memwriteout   = mw_q;
    assign regaddressout = ra_q;
    assign addressout    = addr_q;
    assign storedataout  = sd_q;
    assign branchtaken   = taken_q;
    assign branchtarget  = target_q;
    assign flags         = flags_q;
    assign outport       = outport_q;
    assign outvalid      = outvalid_q;
    assign haltout       = halt_q;

endmodule

// File: tb/tb_p3_execute.sv
// Directed self-checking bench for the p3_execute stage.
module tb_p3_execute;

    logic        clockp3 = 1'b0;
    logic        reset, stall;
    logic [15:0] alu1, alu2, address, storedata, pcp2, inport;
    logic [3:0]  opcode;
    logic        writereg, isbranch, haltin;
    logic [1:0]  memwrite;
    logic [2:0]  regaddress, cond;
    logic [15:0] aluresult, addressout, storedataout, branchtarget, outport;
    logic        writeregout, branchtaken, outvalid, haltout;
    logic [1:0]  memwriteout;
    logic [2:0]  regaddressout;
    logic [3:0]  flags;

    int compared   = 0;
    int mismatched = 0;

    always #5 clockp3 = ~clockp3;

    p3_execute #(.BRANCH_SHADOW(2)) dut (
        .clockp3(clockp3), .reset(reset), .stall(stall),
        .alu1(alu1), .alu2(alu2), .opcode(opcode), .writereg(writereg),
        .memwrite(memwrite), .regaddress(regaddress), .address(address),
        .storedata(storedata), .isbranch(isbranch), .cond(cond), .pcp2(pcp2),
        .haltin(haltin), .inport(inport),
        .aluresult(aluresult), .writeregout(writeregout), .memwriteout(memwriteout),
        .regaddressout(regaddressout), .addressout(addressout),
        .storedataout(storedataout), .branchtaken(branchtaken),
        .branchtarget(branchtarget), .flags(flags), .outport(outport),
        .outvalid(outvalid), .haltout(haltout)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Idle instruction: opcode 7 changes no flags and never writes back
    task automatic nop_inputs();
        stall = 0; alu1 = 0; alu2 = 0; opcode = 4'd7; writereg = 0;
        memwrite = 2'b00; regaddress = 0; address = 0; storedata = 0;
        isbranch = 0; cond = 0; pcp2 = 0; haltin = 0; inport = 0;
    endtask

    task automatic alu_inputs(input logic [3:0] op, input logic [15:0] a,
                              input logic [15:0] b, input logic wr);
        nop_inputs();
        opcode = op; alu1 = a; alu2 = b; writereg = wr;
    endtask

    task automatic branch_inputs(input logic [2:0] c, input logic [15:0] pc,
                                 input logic [15:0] disp);
        nop_inputs();
        isbranch = 1; cond = c; pcp2 = pc; address = disp;
    endtask

    task automatic step(input string name);
        @(posedge clockp3);
        #1;
        $display("step %-14s res=%h wr=%0d mw=%b flags=%b bt=%0d tgt=%h out=%h ov=%0d halt=%0d",
                 name, aluresult, writeregout, memwriteout, flags, branchtaken,
                 branchtarget, outport, outvalid, haltout);
    endtask

    initial begin
        nop_inputs();
        reset = 1;
        step("reset");
        step("reset");
        chk("rst_result", aluresult, 16'h0000);
        chk("rst_flags", 16'(flags), 16'h0);
        chk("rst_wr", 16'(writeregout), 16'd0);
        chk("rst_halt", 16'(haltout), 16'd0);
        chk("rst_outport", outport, 16'h0000);
        reset = 0;

        // ADD overflow into the sign bit, then CMP equal
        alu_inputs(4'd0, 16'h7FFF, 16'h0001, 1); regaddress = 3'd3;
        step("add");
        chk("add_result", aluresult, 16'h8000);
        chk("add_flags", 16'(flags), 16'b1001);
        chk("add_wr", 16'(writeregout), 16'd1);
        chk("add_regaddr", 16'(regaddressout), 16'd3);
        alu_inputs(4'd5, 16'd5, 16'd5, 1);
        step("cmp");
        chk("cmp_flags", 16'(flags), 16'b0100);
        chk("cmp_wr", 16'(writeregout), 16'd0);

        // Shifts
        alu_inputs(4'd11, 16'h8001, 16'h0001, 1);
        step("sra");
        chk("sra_result", aluresult, 16'hC000);
        chk("sra_flags", 16'(flags), 16'b1010);
        alu_inputs(4'd9, 16'h8001, 16'h0004, 1);
        step("slr");
        chk("slr_result", aluresult, 16'h0018);
        chk("slr_flags", 16'(flags), 16'b0000);
        alu_inputs(4'd8, 16'hA5A5, 16'h0010, 1);
        step("sll0");
        chk("sll0_result", aluresult, 16'hA5A5);
        chk("sll0_flags", 16'(flags), 16'b1000);

        // SUB with borrow, AND to zero
        alu_inputs(4'd1, 16'd3, 16'd5, 1);
        step("sub");
        chk("sub_result", aluresult, 16'hFFFE);
        chk("sub_flags", 16'(flags), 16'b1010);
        alu_inputs(4'd2, 16'hF0F0, 16'h0F0F, 1);
        step("and");
        chk("and_flags", 16'(flags), 16'b0100);

        // Load: result zero, pass-through, flags untouched
        alu_inputs(4'd0, 16'd5, 16'd5, 1); memwrite = 2'b01;
        address = 16'h1234; storedata = 16'hBEEF;
        step("load");
        chk("ld_result", aluresult, 16'h0000);
        chk("ld_mw", 16'(memwriteout), 16'd1);
        chk("ld_addr", addressout, 16'h1234);
        chk("ld_sd", storedataout, 16'hBEEF);
        chk("ld_flags", 16'(flags), 16'b0100);

        // BE taken with Z=1; two ADDs squashed, third passes
        branch_inputs(3'd0, 16'h0010, 16'hFFFE);
        step("be");
        chk("be_taken", 16'(branchtaken), 16'd1);
        chk("be_target", branchtarget, 16'h000E);
        alu_inputs(4'd0, 16'd1, 16'd1, 1);
        step("shadow1");
        chk("sh1_wr", 16'(writeregout), 16'd0);
        chk("sh1_bt", 16'(branchtaken), 16'd0);
        chk("sh1_flags", 16'(flags), 16'b0100);
        step("shadow2");
        chk("sh2_wr", 16'(writeregout), 16'd0);
        step("pass");
        chk("pass_wr", 16'(writeregout), 16'd1);
        chk("pass_result", aluresult, 16'h0002);
        chk("pass_flags", 16'(flags), 16'b0000);

        // BE not taken with Z=0
        branch_inputs(3'd0, 16'h0010, 16'h0004);
        step("be_nt");
        chk("be_nt_taken", 16'(branchtaken), 16'd0);
        alu_inputs(4'd0, 16'd2, 16'd3, 1);
        step("after_nt");
        chk("after_nt_wr", 16'(writeregout), 16'd1);

        // BNE taken, then 3 stall cycles; shadow still covers 2 instructions
        branch_inputs(3'd3, 16'h0100, 16'h0020);
        step("bne");
        chk("bne_taken", 16'(branchtaken), 16'd1);
        chk("bne_target", branchtarget, 16'h0120);
        alu_inputs(4'd0, 16'hFFFF, 16'h0001, 1);
        stall = 1;
        step("stall1");
        chk("stall_bt", 16'(branchtaken), 16'd0);
        chk("stall_wr", 16'(writeregout), 16'd0);
        step("stall2");
        step("stall3");
        chk("stall_flags", 16'(flags), 16'b0000);
        stall = 0;
        step("post_sh1");
        chk("psh1_wr", 16'(writeregout), 16'd0);
        step("post_sh2");
        chk("psh2_wr", 16'(writeregout), 16'd0);
        step("post_pass");
        chk("ppass_wr", 16'(writeregout), 16'd1);
        chk("ppass_flags", 16'(flags), 16'b0110);

        // OUT pulse
        alu_inputs(4'd13, 16'h1234, 16'h0000, 0);
        step("out");
        chk("out_port", outport, 16'h1234);
        chk("out_valid", 16'(outvalid), 16'd1);
        nop_inputs();
        step("out_after");
        chk("out_valid_clr", 16'(outvalid), 16'd0);
        chk("out_port_hold", outport, 16'h1234);

        // HLT, then a suppressed store, then reset
        nop_inputs(); opcode = 4'd15; haltin = 1;
        step("hlt");
        chk("hlt_halt", 16'(haltout), 16'd1);
        nop_inputs(); opcode = 4'd0; memwrite = 2'b10; address = 16'h0040;
        step("store_halted");
        chk("halted_mw", 16'(memwriteout), 16'd0);
        chk("halted_sticky", 16'(haltout), 16'd1);
        nop_inputs(); reset = 1;
        step("reset2");
        reset = 0;
        chk("rst2_halt", 16'(haltout), 16'd0);
        chk("rst2_flags", 16'(flags), 16'h0);

        // Condition 5 is never taken
        branch_inputs(3'd5, 16'h0020, 16'h0002);
        step("never");
        chk("never_taken", 16'(branchtaken), 16'd0);

        // Reset in the middle of a shadow clears the counter
        branch_inputs(3'd4, 16'h0030, 16'h0005);
        step("b_always");
        chk("b_taken", 16'(branchtaken), 16'd1);
        chk("b_target", branchtarget, 16'h0035);
        alu_inputs(4'd0, 16'd1, 16'd1, 1);
        step("mid_shadow");
        chk("mid_wr", 16'(writeregout), 16'd0);
        reset = 1;
        step("reset3");
        reset = 0;
        chk("rst3_wr", 16'(writeregout), 16'd0);
        step("post_reset");
        chk("prst_wr", 16'(writeregout), 16'd1);
        chk("prst_result", aluresult, 16'h0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
